// File: rtl/sigma_delta_adc_pkg.sv
// rtl/sigma_delta_adc_pkg.sv - shared audio excess-code definitions for ADC and DAC
package sigma_delta_adc_pkg;

  // Excess-code sample width shared by the capture and playback paths
  localparam int SDADC_W = 8;

  // Midscale code: the zero-signal point of the excess-2**(W-1) format
  localparam int SDADC_MID = 2 ** (SDADC_W - 1);

  typedef logic [SDADC_W-1:0] sdadc_code_t;

  // Midscale for an arbitrary sample width
  function automatic int sdadc_mid(input int w);
    return 2 ** (w - 1);
  endfunction

endpackage

// File: rtl/sdadc_sync2.sv
// rtl/sdadc_sync2.sv - two-flop synchronizer for asynchronous pin inputs
module sdadc_sync2 (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use in the Clk domain
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// rtl/sigma_delta_adc.sv - first-order sigma-delta ADC with boxcar decimation
module sigma_delta_adc
  import sigma_delta_adc_pkg::*;
#(
  parameter int DECIM_LOG2 = SDADC_W,
  parameter int HYST       = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  comp_in,
  output logic                  fb_out,
  output logic [DECIM_LOG2-1:0] sample,
  output logic                  sample_valid,
  output logic                  ear_level,
  output logic                  clip,
  input  logic                  clip_clr
);

  localparam int W = DECIM_LOG2;
  localparam logic [W-1:0] MID     = W'(sdadc_mid(W));
  localparam logic [W-1:0] EAR_HI  = W'(sdadc_mid(W) + HYST);
  localparam logic [W-1:0] EAR_LO  = W'(sdadc_mid(W) - HYST);
  localparam logic [W:0]   FULL    = {1'b1, {W{1'b0}}};

  logic         comp_s;
  logic [W-1:0] cnt;
  logic [W:0]   acc;
  logic [W:0]   sum;
  logic [W-1:0] sat;
  logic         end_win;
  logic         clip_hit;

  sdadc_sync2 u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (comp_in),
    .q     (comp_s)
  );

  // Window total including the current bit; the extra acc bit holds an all-ones window
  assign sum      = acc + {{W{1'b0}}, comp_s};
  assign end_win  = enable && (cnt == {W{1'b1}});
  assign sat      = sum[W] ? {W{1'b1}} : sum[W-1:0];
  assign clip_hit = (sum == '0) || (sum == FULL);

  // Feedback follows the comparator regardless of enable so the analog loop never opens
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_out <= 1'b0;
    end else begin
      fb_out <= comp_s;
    end
  end

  // Decimator: count ones over a full window; disabling discards any partial window
  always_ff @(posedge Clk) begin
    if (Reset || !enable) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      acc <= end_win ? '0 : sum;
    end
  end

  // Sample register and one-cycle valid strobe at the end of each window
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample       <= MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= end_win;
      if (end_win) begin
        sample <= sat;
      end
    end
  end

  // EAR slicer with hysteresis around midscale, updated only with new samples
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ear_level <= 1'b0;
    end else if (end_win) begin
      if (sat >= EAR_HI) begin
        ear_level <= 1'b1;
      end else if (sat <= EAR_LO) begin
        ear_level <= 1'b0;
      end
    end
  end

  // Sticky clip flag; a window hitting a rail beats a simultaneous clear
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clip <= 1'b0;
    end else if (end_win && clip_hit) begin
      clip <= 1'b1;
    end else if (clip_clr) begin
      clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// tb/tb_sigma_delta_adc.sv - self-checking bench for sigma_delta_adc
module tb_sigma_delta_adc;
  import sigma_delta_adc_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       enable;
  logic       comp_in;
  logic       clip_clr;
  logic       fb_out;
  logic [7:0] sample;
  logic       sample_valid;
  logic       ear_level;
  logic       clip;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int ph    = 0;

  typedef struct {
    logic [7:0] s;
    logic       ear;
  } exp_t;

  exp_t sb[$];

  sigma_delta_adc #(.DECIM_LOG2(8), .HYST(16)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ear_level    (ear_level),
    .clip         (clip),
    .clip_clr     (clip_clr)
  );

  always #5 Clk = ~Clk;

  // Comparator pattern source: 0 zeros, 1 ones, 2 toggle, 3 25% ones, 4 75% ones
  initial begin
    comp_in = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      ph++;
      case (mode)
        1:       comp_in = 1'b1;
        2:       comp_in = ph[0];
        3:       comp_in = ((ph % 4) == 0);
        4:       comp_in = ((ph % 4) != 0);
        default: comp_in = 1'b0;
      endcase
    end
  end

  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      @(negedge Clk);
      n++;
      if (sample_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    enable   = 1'b0;
    clip_clr = 1'b0;
    mode     = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (sample !== 8'h80) begin bad++; $display("FAIL reset_sample got=%h exp=80", sample); end
    total++; if (fb_out !== 1'b0) begin bad++; $display("FAIL reset_fb got=%b exp=0", fb_out); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    total++; if (ear_level !== 1'b0) begin bad++; $display("FAIL reset_ear got=%b exp=0", ear_level); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip got=%b exp=0", clip); end
    Reset = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e;
    int   n;
    bit   ok;
    @(negedge Clk);
    enable = 1'b1;
    mode   = 1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (fb_out !== 1'b0) begin bad++; $display("FAIL fb_early got=%b exp=0", fb_out); end
    @(negedge Clk);
    total++; if (fb_out !== 1'b1) begin bad++; $display("FAIL fb_latency got=%b exp=1", fb_out); end
    sb.push_back('{8'hFD, 1'b1});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_first_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL sat_first_sample got=%h exp=%h", sample, e.s); end
    total++; if (ear_level !== e.ear) begin bad++; $display("FAIL sat_first_ear got=%b exp=%b", ear_level, e.ear); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL sat_first_clip got=%b exp=0", clip); end
    sb.push_back('{8'hFF, 1'b1});
    wait_valid(n, ok);
    total++; if (n != 256 || !ok) begin bad++; $display("FAIL sat_spacing got=%0d exp=256", n); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL sat_sample got=%h exp=%h", sample, e.s); end
    total++; if (ear_level !== e.ear) begin bad++; $display("FAIL sat_ear got=%b exp=%b", ear_level, e.ear); end
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL sat_clip got=%b exp=1", clip); end
  endtask

  task automatic test_toggle();
    exp_t e;
    int   n;
    bit   ok;
    mode = 2;
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL toggle_settle_timeout got=none exp=pulse"); end
    sb.push_back('{8'h80, 1'b1});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL toggle_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL toggle_sample got=%h exp=%h", sample, e.s); end
    total++; if (ear_level !== e.ear) begin bad++; $display("FAIL toggle_ear_hold got=%b exp=%b", ear_level, e.ear); end
  endtask

  task automatic test_density();
    exp_t e;
    int   n;
    bit   ok;
    mode = 3;
    wait_valid(n, ok);
    sb.push_back('{8'h40, 1'b0});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL d25_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL d25_sample got=%h exp=%h", sample, e.s); end
    total++; if (ear_level !== e.ear) begin bad++; $display("FAIL d25_ear got=%b exp=%b", ear_level, e.ear); end
    mode = 4;
    wait_valid(n, ok);
    sb.push_back('{8'hC0, 1'b1});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL d75_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL d75_sample got=%h exp=%h", sample, e.s); end
    total++; if (ear_level !== e.ear) begin bad++; $display("FAIL d75_ear got=%b exp=%b", ear_level, e.ear); end
  endtask

  task automatic test_enable_gap();
    exp_t e;
    int   n;
    bit   ok;
    int   pulses;
    repeat (100) @(posedge Clk);
    @(negedge Clk);
    enable = 1'b0;
    pulses = 0;
    repeat (50) begin
      @(negedge Clk);
      if (sample_valid !== 1'b0) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL gap_pulses got=%0d exp=0", pulses); end
    total++; if (sample !== 8'hC0) begin bad++; $display("FAIL gap_hold got=%h exp=c0", sample); end
    enable = 1'b1;
    sb.push_back('{8'hC0, 1'b1});
    wait_valid(n, ok);
    total++; if (n != 256 || !ok) begin bad++; $display("FAIL gap_restart got=%0d exp=256", n); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL gap_sample got=%h exp=%h", sample, e.s); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    bit   ok;
    mode = 1;
    wait_valid(n, ok);
    repeat (100) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    total++; if (sample !== 8'h80) begin bad++; $display("FAIL rmid_sample got=%h exp=80", sample); end
    total++; if (ear_level !== 1'b0) begin bad++; $display("FAIL rmid_ear got=%b exp=0", ear_level); end
    total++; if (fb_out !== 1'b0) begin bad++; $display("FAIL rmid_fb got=%b exp=0", fb_out); end
    Reset = 1'b0;
    sb.push_back('{8'hFE, 1'b1});
    wait_valid(n, ok);
    total++; if (n != 256 || !ok) begin bad++; $display("FAIL rmid_spacing got=%0d exp=256", n); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL rmid_first got=%h exp=%h", sample, e.s); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL rmid_clip got=%b exp=0", clip); end
    sb.push_back('{8'hFF, 1'b1});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_second_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL rmid_second got=%h exp=%h", sample, e.s); end
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL rmid_second_clip got=%b exp=1", clip); end
  endtask

  task automatic test_clip_clr();
    exp_t e;
    int   n;
    bit   ok;
    @(negedge Clk);
    clip_clr = 1'b1;
    @(negedge Clk);
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b exp=0", clip); end
    sb.push_back('{8'hFF, 1'b1});
    wait_valid(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL clr_timeout got=none exp=pulse"); end
    e = sb.pop_front();
    total++; if (sample !== e.s) begin bad++; $display("FAIL clr_sample got=%h exp=%h", sample, e.s); end
    total++; if (clip !== 1'b1) begin bad++; $display("FAIL clr_set_wins got=%b exp=1", clip); end
    @(negedge Clk);
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL clr_after got=%b exp=0", clip); end
    clip_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_toggle();
    test_density();
    test_enable_gap();
    test_reset_mid();
    test_clip_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
